player_motion: RTL and testbench

PLAYER_MOTION -- requirements
Module: player_motion

---
 rtl/player_motion.sv | 229 ++++++++++++++++++++++
 tb/tb_player_motion.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
//  Module      : player_motion
//  Description : Tile-stepped player movement controller. A frame tick,
//                derived from the VGA vertical sync, advances a small FSM that
//                handles turning in place, asking the map whether the next tile
//                is free, and walking one pixel per frame into it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk              in   system clock
//    Reset            in   asynchronous reset, active low
//    frame_clk        in   vertical-sync level, asynchronous to Clk
//    keycode[7:0]     in   USB HID keycode (W/D/S/A = up/right/down/left)
//    blocked          in   map collision result for TargetX/TargetY
//    query_valid      out  high while the map is being queried (CHECK)
//    TargetX/Y[9:0]   out  world pixel of the tile about to be entered
//    PosX/Y[9:0]      out  player world position (top-left)
//    Direction[1:0]   out  facing: 0 up, 1 right, 2 down, 3 left
//    Character_Moving out  high while turning or walking
// ============================================================================
module player_motion #(
    parameter int STEP_PIXELS = 16,
    parameter int TURN_FRAMES = 4,
    parameter int MAP_W       = 640,
    parameter int MAP_H       = 480,
    parameter int START_X     = 304,
    parameter int START_Y     = 224
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       blocked,
    output logic       query_valid,
    output logic [9:0] TargetX,
    output logic [9:0] TargetY,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [1:0] Direction,
    output logic       Character_Moving
);

    localparam int SW = $clog2(STEP_PIXELS);
    localparam int TW = $clog2(TURN_FRAMES + 1);

    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_PIXELS - 1);
    localparam logic [TW-1:0]       TURN_INIT = TW'(TURN_FRAMES - 1);
    localparam logic signed [11:0]  STEP_S    = 12'(STEP_PIXELS);
    localparam logic signed [11:0]  MAX_X     = 12'(MAP_W - STEP_PIXELS);
    localparam logic signed [11:0]  MAX_Y     = 12'(MAP_H - STEP_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_CHECK = 2'd2,
        S_WALK  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [9:0]    tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [1:0]    dir_q, dir_d;
    logic [TW-1:0] turn_q, turn_d;
    logic [SW-1:0] step_q, step_d;
    logic          oob_q, oob_d;
    logic          moving_q, moving_d;
    logic          fs1_q, fs2_q, fs3_q, tick_q, tick_d;

    logic          key_valid;
    logic [1:0]    key_dir;
    logic [9:0]    step_x, step_y, base_x, base_y;
    logic signed [11:0] tx, ty;
    logic          oob;

    // fs1/fs2 resynchronise vsync; fs3 holds the previous level for edge detect
    assign tick_d = fs2_q & ~fs3_q;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = 2'd0;
        case (keycode)
            8'h1A:   key_dir = 2'd0;
            8'h07:   key_dir = 2'd1;
            8'h16:   key_dir = 2'd2;
            8'h04:   key_dir = 2'd3;
            default: key_valid = 1'b0;
        endcase
    end

    // Position after one more pixel in the facing direction
    always_comb begin
        step_x = pos_x_q;
        step_y = pos_y_q;
        case (dir_q)
            2'd0:    step_y = pos_y_q - 10'd1;
            2'd1:    step_x = pos_x_q + 10'd1;
            2'd2:    step_y = pos_y_q + 10'd1;
            default: step_x = pos_x_q - 10'd1;
        endcase
    end

    // The next target is measured from where the player will stand once the
    // current transition completes: the final walk pixel is applied in the
    // same tick that chains into the next CHECK.
    // Targets use 12-bit signed math so a step left/up from 0 is seen as
    // negative rather than wrapping to a large 10-bit value.
    always_comb begin
        base_x = (state_q == S_WALK) ? step_x : pos_x_q;
        base_y = (state_q == S_WALK) ? step_y : pos_y_q;
        tx     = $signed({2'b00, base_x});
        ty     = $signed({2'b00, base_y});
        case (dir_q)
            2'd0:    ty = ty - STEP_S;
            2'd1:    tx = tx + STEP_S;
            2'd2:    ty = ty + STEP_S;
            default: tx = tx - STEP_S;
        endcase
        oob = (tx < 12'sd0) || (tx > MAX_X) || (ty < 12'sd0) || (ty > MAX_Y);
    end

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        dir_d   = dir_q;
        turn_d  = turn_q;
        step_d  = step_q;
        oob_d   = oob_q;
        case (state_q)
            S_IDLE: begin
                if (tick_q && key_valid) begin
                    if (key_dir != dir_q) begin
                        dir_d   = key_dir;
                        turn_d  = TURN_INIT;
                        state_d = S_TURN;
                    end else begin
                        tgt_x_d = tx[9:0];
                        tgt_y_d = ty[9:0];
                        oob_d   = oob;
                        state_d = S_CHECK;
                    end
                end
            end
            S_TURN: begin
                if (tick_q) begin
                    if (turn_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        turn_d = turn_q - 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (blocked || oob_q) begin
                    state_d = S_IDLE;
                end else begin
                    step_d  = '0;
                    state_d = S_WALK;
                end
            end
            default: begin
                if (tick_q) begin
                    pos_x_d = step_x;
                    pos_y_d = step_y;
                    step_d  = step_q + 1'b1;
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (key_valid && key_dir == dir_q) begin
                            tgt_x_d = tx[9:0];
                            tgt_y_d = ty[9:0];
                            oob_d   = oob;
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
        endcase
        moving_d = (state_d == S_TURN) || (state_d == S_WALK);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            pos_x_q  <= 10'(START_X);
            pos_y_q  <= 10'(START_Y);
            tgt_x_q  <= '0;
            tgt_y_q  <= '0;
            dir_q    <= 2'd0;
            turn_q   <= '0;
            step_q   <= '0;
            oob_q    <= 1'b0;
            moving_q <= 1'b0;
            fs1_q    <= 1'b0;
            fs2_q    <= 1'b0;
            fs3_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            tgt_x_q  <= tgt_x_d;
            tgt_y_q  <= tgt_y_d;
            dir_q    <= dir_d;
            turn_q   <= turn_d;
            step_q   <= step_d;
            oob_q    <= oob_d;
            moving_q <= moving_d;
            fs1_q    <= frame_clk;
            fs2_q    <= fs1_q;
            fs3_q    <= fs2_q;
            tick_q   <= tick_d;
        end
    end

    assign query_valid      = (state_q == S_CHECK);
    assign TargetX          = tgt_x_q;
    assign TargetY          = tgt_y_q;
    assign PosX             = pos_x_q;
    assign PosY             = pos_y_q;
    assign Direction        = dir_q;
    assign Character_Moving = moving_q;

endmodule
`default_nettype wire

// File: tb/tb_player_motion.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_motion
//  Description : Directed self-checking bench for player_motion. Each frame is
//                an 8-clock vsync pulse, long enough for the synchroniser,
//                the FSM step and any following CHECK to settle inside it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       blocked;
    logic       query_valid;
    logic [9:0] TargetX, TargetY, PosX, PosY;
    logic [1:0] Direction;
    logic       Character_Moving;

    int checks = 0;
    int errors = 0;
    int qv_cnt = 0;
    int qv_mark;
    logic [9:0] qv_ty;

    player_motion dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .keycode          (keycode),
        .blocked          (blocked),
        .query_valid      (query_valid),
        .TargetX          (TargetX),
        .TargetY          (TargetY),
        .PosX             (PosX),
        .PosY             (PosY),
        .Direction        (Direction),
        .Character_Moving (Character_Moving)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count every clock spent in CHECK and remember the target shown there
    always @(negedge Clk) begin
        if (query_valid === 1'b1) begin
            qv_cnt++;
            qv_ty = TargetY;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) frame_clk = 1'b1;
            repeat (4) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    initial begin
        Reset     = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        blocked   = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset state
        check("rst_posx", 32'(PosX), 304);
        check("rst_posy", 32'(PosY), 224);
        check("rst_dir", 32'(Direction), 0);
        check("rst_moving", 32'(Character_Moving), 0);
        check("rst_qv", 32'(query_valid), 0);
        check("rst_tgtx", 32'(TargetX), 0);
        check("rst_tgty", 32'(TargetY), 0);
        @(negedge Clk) Reset = 1'b1;
        repeat (2) @(negedge Clk);

        // No key: stays idle
        frames(2);
        check("nokey_qv_cnt", 32'(qv_cnt), 0);
        check("nokey_moving", 32'(Character_Moving), 0);

        // Step up while already facing up: CHECK then 16 walk frames
        keycode = 8'h1A;
        frames(1);
        check("up_qv_cnt", 32'(qv_cnt), 1);
        check("up_tgty", 32'(TargetY), 208);
        check("up_tgtx", 32'(TargetX), 304);
        check("up_moving", 32'(Character_Moving), 1);
        check("up_posy0", 32'(PosY), 224);
        keycode = 8'h00;                 // ignored until the final pixel
        frames(8);
        check("up_posy8", 32'(PosY), 216);
        check("up_moving8", 32'(Character_Moving), 1);
        frames(8);
        check("up_posy_done", 32'(PosY), 208);
        check("up_moving_done", 32'(Character_Moving), 0);
        check("up_dir", 32'(Direction), 0);
        frames(1);
        check("up_posy_idle", 32'(PosY), 208);

        // Blocked: one CHECK clock, target 192, no motion
        keycode = 8'h1A;
        blocked = 1'b1;
        frames(1);
        check("blk_qv_cnt", 32'(qv_cnt), 2);
        check("blk_tgty", 32'(qv_ty), 192);
        check("blk_posy", 32'(PosY), 208);
        check("blk_moving", 32'(Character_Moving), 0);
        blocked = 1'b0;

        // Turn right: 4 frames of TURN, then a CHECK and a walk
        keycode = 8'h07;
        frames(1);
        check("turn_dir", 32'(Direction), 1);
        check("turn_moving1", 32'(Character_Moving), 1);
        frames(3);
        check("turn_moving4", 32'(Character_Moving), 1);
        check("turn_qv_cnt", 32'(qv_cnt), 2);
        frames(1);
        check("turn_idle_moving", 32'(Character_Moving), 0);
        check("turn_posx", 32'(PosX), 304);
        frames(1);
        check("right_tgtx", 32'(TargetX), 320);
        check("right_qv_cnt", 32'(qv_cnt), 3);
        frames(15);
        keycode = 8'h00;
        frames(1);
        check("right_posx", 32'(PosX), 320);
        check("right_posy", 32'(PosY), 208);
        check("right_moving", 32'(Character_Moving), 0);

        // Face down, then two back-to-back steps with the key held
        keycode = 8'h16;
        frames(5);
        check("down_dir", 32'(Direction), 2);
        check("down_idle", 32'(Character_Moving), 0);
        frames(1);
        check("down_tgty1", 32'(TargetY), 224);
        frames(16);
        check("down_posy1", 32'(PosY), 224);
        check("down_chain_moving", 32'(Character_Moving), 1);
        check("down_tgty2", 32'(TargetY), 240);
        check("down_qv_cnt", 32'(qv_cnt), 5);
        frames(15);
        keycode = 8'h00;
        frames(1);
        check("down_posy2", 32'(PosY), 240);
        check("down_moving", 32'(Character_Moving), 0);

        // Walk left to the edge; the step off the map must be rejected
        keycode = 8'h04;
        frames(5);
        check("left_dir", 32'(Direction), 3);
        frames(1 + 20 * 16);
        check("left_posx0", 32'(PosX), 0);
        check("left_moving", 32'(Character_Moving), 0);
        qv_mark = qv_cnt;
        frames(2);
        check("left_qv_retry", 32'(qv_cnt - qv_mark), 2);
        check("left_nowrap", 32'(PosX), 0);
        check("left_posy", 32'(PosY), 240);

        // Reset in the middle of a walk
        keycode = 8'h07;
        frames(6);
        frames(7);
        check("mid_posx", 32'(PosX), 7);
        check("mid_moving", 32'(Character_Moving), 1);
        Reset = 1'b0;
        #1;
        check("arst_posx", 32'(PosX), 304);
        check("arst_posy", 32'(PosY), 224);
        check("arst_dir", 32'(Direction), 0);
        check("arst_moving", 32'(Character_Moving), 0);
        check("arst_qv", 32'(query_valid), 0);
        check("arst_tgtx", 32'(TargetX), 0);
        keycode = 8'h00;
        @(negedge Clk) Reset = 1'b1;
        frames(2);
        check("post_posx", 32'(PosX), 304);
        check("post_moving", 32'(Character_Moving), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
